// File: rtl/miner_mm_multi.sv
// miner_mm_multi: Avalon-MM register front end for a bank of miner cores.
// Drives the shared header/difficulty/control and gives each core its own
// slice of the nonce space. Solutions go from per-core holding slots into a
// solution FIFO, and a level IRQ is raised while that FIFO holds entries.
module miner_mm_multi #(
  parameter int NUM_CORES  = 4,
  parameter int NONCE_W    = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_MHZ    = 60,
  parameter int MAJ_VER    = 0,
  parameter int MIN_VER    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [5:0]                     address,
  input  logic                           read,
  input  logic                           write,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  output logic                           irq,
  output logic [255:0]                   core_header,
  output logic [255:0]                   core_difficulty,
  output logic [17:0]                    core_control,
  output logic [NUM_CORES*NONCE_W-1:0]   core_start,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_solution,
  input  logic [NUM_CORES-1:0]           core_running
);

  localparam int NWORDS     = NONCE_W / 32;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  // Each core owns an equal 2^NONCE_W / NUM_CORES slice of the nonce space.
  localparam int PART_SHIFT = NONCE_W - $clog2(NUM_CORES);

  // Control register fields
  logic       run_reg;
  logic       test_reg;
  logic       irq_en_reg;
  logic [7:0] pad_last_reg;
  logic [7:0] pad_first_reg;
  logic       ovf_reg;

  // FIFO state
  logic [NONCE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   fifo_count_reg;
  logic [NONCE_W-1:0] fifo_head;
  logic               fifo_empty;

  // Slot / drain signals
  logic [NUM_CORES-1:0]         slot_full;
  logic [NUM_CORES*NONCE_W-1:0] slot_data;
  logic [NUM_CORES-1:0]         drain_sel;
  logic [NUM_CORES-1:0]         drop;
  logic                         drain_hit;
  logic [NONCE_W-1:0]           push_data;
  logic                         push_room;
  logic                         push_en;

  logic               wr_ctl;
  logic               run_rise;
  logic               pop;
  logic               clr_ovf;
  logic [NONCE_W-1:0] start_cat;
  logic [31:0]        rd_data;

  assign wr_ctl     = write && (address == 6'd28);
  assign run_rise   = wr_ctl && writedata[0] && !run_reg;
  assign fifo_empty = (fifo_count_reg == '0);
  assign pop        = wr_ctl && writedata[2] && !fifo_empty;
  assign clr_ovf    = wr_ctl && writedata[3];
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  assign core_control = {pad_first_reg, pad_last_reg, test_reg, run_reg};

  // Header and difficulty words; word0 sits in the most significant position.
  for (genvar gi = 0; gi < 8; gi++) begin : g_words
    logic [31:0] hdr_q;
    logic [31:0] diff_q;

    // Header/difficulty register writes
    always_ff @(posedge clk) begin
      if (rst) begin
        hdr_q  <= '0;
        diff_q <= '0;
      end else if (write) begin
        if (address == 6'(8 + gi))  hdr_q  <= writedata;
        if (address == 6'(16 + gi)) diff_q <= writedata;
      end
    end

    assign core_header[(7-gi)*32 +: 32]     = hdr_q;
    assign core_difficulty[(7-gi)*32 +: 32] = diff_q;
  end

  // START words; only those covering the nonce width are stored.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_start
    logic [31:0] start_q;

    // START register write
    always_ff @(posedge clk) begin
      if (rst)
        start_q <= '0;
      else if (write && address == 6'(24 + gi))
        start_q <= writedata;
    end

    assign start_cat[gi*32 +: 32] = start_q;
  end

  // CTL register; pop and clr_ovf are strobes and are not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg       <= 1'b0;
      test_reg      <= 1'b0;
      irq_en_reg    <= 1'b0;
      pad_last_reg  <= '0;
      pad_first_reg <= '0;
    end else if (wr_ctl) begin
      run_reg       <= writedata[0];
      test_reg      <= writedata[1];
      irq_en_reg    <= writedata[4];
      pad_last_reg  <= writedata[23:16];
      pad_first_reg <= writedata[31:24];
    end
  end

  // Per-core start nonce, latched only when run goes 0->1.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_part
    logic [NONCE_W-1:0] cs_q;

    // Latch the partitioned start nonce on a run rising write
    always_ff @(posedge clk) begin
      if (rst)
        cs_q <= '0;
      else if (run_rise)
        cs_q <= start_cat + (NONCE_W'(gi) << PART_SHIFT);
    end

    assign core_start[gi*NONCE_W +: NONCE_W] = cs_q;
  end

  // A pop frees a FIFO entry in the same cycle, so a full FIFO can still accept.
  assign push_room = (fifo_count_reg != CNT_W'(FIFO_DEPTH)) || pop;

  // Pick the lowest-index full slot to drain into the FIFO.
  always_comb begin
    drain_sel = '0;
    drain_hit = 1'b0;
    push_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (slot_full[i] && !drain_hit) begin
        drain_sel[i] = push_room;
        drain_hit    = 1'b1;
      end
      if (drain_sel[i])
        push_data = slot_data[i*NONCE_W +: NONCE_W];
    end
  end

  assign push_en = |drain_sel;

  // Holding slots; a slot draining this cycle may capture a new find.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
    logic               full_q;
    logic [NONCE_W-1:0] data_q;
    logic               slot_free;

    assign slot_free = !full_q || drain_sel[gi];
    assign drop[gi]  = core_found[gi] && !slot_free;
    assign slot_full[gi] = full_q;
    assign slot_data[gi*NONCE_W +: NONCE_W] = data_q;

    // Slot occupancy: capture wins over drain when both happen
    always_ff @(posedge clk) begin
      if (rst)
        full_q <= 1'b0;
      else if (core_found[gi] && slot_free)
        full_q <= 1'b1;
      else if (drain_sel[gi])
        full_q <= 1'b0;
    end

    // Slot payload capture
    always_ff @(posedge clk) begin
      if (core_found[gi] && slot_free)
        data_q <= core_solution[gi*NONCE_W +: NONCE_W];
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (|drop)
      ovf_reg <= 1'b1;
    else if (clr_ovf)
      ovf_reg <= 1'b0;
  end

  // Solution FIFO storage
  always_ff @(posedge clk) begin
    if (push_en)
      fifo_mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_en && !pop)
        fifo_count_reg <= fifo_count_reg + 1'b1;
      else if (pop && !push_en)
        fifo_count_reg <= fifo_count_reg - 1'b1;
    end
  end

  // Level interrupt while solutions are pending
  always_ff @(posedge clk) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= irq_en_reg && !fifo_empty;
  end

  // Register read mux
  always_comb begin
    rd_data = '0;
    if (address[5:2] == 4'd0) begin
      for (int w = 0; w < NWORDS; w++)
        if (address[1:0] == 2'(w) && !fifo_empty)
          rd_data = fifo_head[w*32 +: 32];
    end else if (address == 6'd4) begin
      rd_data = {8'(fifo_count_reg), 4'(MIN_VER), 4'(MAJ_VER), 8'(CLK_MHZ),
                 3'b000, ovf_reg, fifo_empty, test_reg, |core_running, irq};
    end else if (address == 6'd5) begin
      rd_data = 32'h5348_4133;
    end else if (address == 6'd6) begin
      rd_data = {8'h00, 8'(FIFO_DEPTH), 8'(NONCE_W), 8'(NUM_CORES)};
    end else if (address[5:3] == 3'd1) begin
      rd_data = core_header[(7 - address[2:0])*32 +: 32];
    end else if (address[5:3] == 3'd2) begin
      rd_data = core_difficulty[(7 - address[2:0])*32 +: 32];
    end else if (address[5:2] == 4'd6) begin
      for (int w = 0; w < NWORDS; w++)
        if (address[1:0] == 2'(w))
          rd_data = start_cat[w*32 +: 32];
    end else if (address == 6'd28) begin
      rd_data = {pad_first_reg, pad_last_reg, 11'd0, irq_en_reg, 2'b00,
                 test_reg, run_reg};
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (rst)
      readdata <= '0;
    else if (read)
      readdata <= rd_data;
  end

endmodule

// File: tb/tb_miner_mm_multi.sv
// Directed testbench for miner_mm_multi with default parameters.
module tb_miner_mm_multi;

  localparam int NC = 4;
  localparam int NW = 64;
  localparam logic [31:0] CTLV = 32'h8006_0011;  // run, irq_en, pads

  logic           clk;
  logic           rst;
  logic [5:0]     address;
  logic           read;
  logic           write;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           irq;
  logic [255:0]   core_header;
  logic [255:0]   core_difficulty;
  logic [17:0]    core_control;
  logic [NC*NW-1:0] core_start;
  logic [NC-1:0]  core_found;
  logic [NC*NW-1:0] core_solution;
  logic [NC-1:0]  core_running;

  int checks = 0;
  int errors = 0;

  miner_mm_multi dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .core_header(core_header), .core_difficulty(core_difficulty),
    .core_control(core_control), .core_start(core_start),
    .core_found(core_found), .core_solution(core_solution),
    .core_running(core_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    $display("wr  addr=%0d data=%08h", a, d);
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
    $display("rd  addr=%0d data=%08h", a, d);
  endtask

  task automatic find(input logic [NC-1:0] mask, input logic [NW-1:0] sol);
    @(negedge clk);
    core_found = mask;
    for (int i = 0; i < NC; i++)
      if (mask[i]) core_solution[i*NW +: NW] = sol + 64'(i);
    @(negedge clk);
    core_found = '0;
    $display("find mask=%b sol=%016h", mask, sol);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else
      $display("ok   %s = %0h", name, got);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_readdata", 64'(readdata), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);
    chk("reset_core_start", core_start[63:0], 64'h0);
    rd(6'd4, d);  chk("reset_stat", 64'(d), 64'h0000_3C08);
    rd(6'd5, d);  chk("id", 64'(d), 64'h5348_4133);
    rd(6'd6, d);  chk("cfg", 64'(d), 64'h0008_4004);
    rd(6'd0, d);  chk("empty_soln", 64'(d), 64'h0);
  endtask

  task automatic test_regs;
    logic [31:0] d;
    wr(6'd8, 32'h0123_4567);
    wr(6'd15, 32'h89AB_CDEF);
    wr(6'd16, 32'h5555_AAAA);
    chk("hdr_word0_out", 64'(core_header[255:224]), 64'h0123_4567);
    chk("hdr_word7_out", 64'(core_header[31:0]), 64'h89AB_CDEF);
    chk("diff_word0_out", 64'(core_difficulty[255:224]), 64'h5555_AAAA);
    rd(6'd15, d); chk("hdr_word7_rd", 64'(d), 64'h89AB_CDEF);
    rd(6'd7, d);  chk("reserved_rd", 64'(d), 64'h0);
  endtask

  task automatic test_partition;
    logic [31:0] d;
    logic [63:0] exp_start [NC];
    exp_start[0] = 64'h0000_0001_0000_0000;
    exp_start[1] = 64'h4000_0001_0000_0000;
    exp_start[2] = 64'h8000_0001_0000_0000;
    exp_start[3] = 64'hC000_0001_0000_0000;
    wr(6'd24, 32'h0);
    wr(6'd25, 32'h1);
    wr(6'd28, 32'h1);
    for (int i = 0; i < NC; i++)
      chk($sformatf("core_start%0d", i), core_start[i*NW +: NW], exp_start[i]);
    wr(6'd24, 32'hDEAD_BEEF);
    chk("start_hold_running", core_start[63:0], exp_start[0]);
    rd(6'd24, d); chk("start_word0_rd", 64'(d), 64'hDEAD_BEEF);
    core_running = 4'b0100;
    rd(6'd4, d);  chk("stat_running", 64'(d[1]), 64'h1);
    core_running = '0;
    wr(6'd28, CTLV);
    chk("core_control", 64'(core_control), 64'h2_0019);
    chk("start_hold_ctl", core_start[127:64], exp_start[1]);
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    find(4'b1011, 64'h1111_2222_3333_4440);
    chk("irq_after_find", 64'(irq), 64'h0);
    @(negedge clk); chk("irq_cycle1", 64'(irq), 64'h0);
    @(negedge clk); chk("irq_cycle2", 64'(irq), 64'h1);
    @(negedge clk);
    rd(6'd4, d);
    chk("count_3", 64'(d[31:24]), 64'h3);
    chk("stat_irq_notempty", 64'({d[3], d[0]}), 64'h1);
  endtask

  task automatic test_pop_irq;
    logic [31:0] d;
    rd(6'd0, d); chk("head0_w0", 64'(d), 64'h3333_4440);
    rd(6'd1, d); chk("head0_w1", 64'(d), 64'h1111_2222);
    wr(6'd28, CTLV | 32'h4);
    rd(6'd0, d); chk("head1_w0", 64'(d), 64'h3333_4441);
    rd(6'd28, d); chk("ctl_rd", 64'(d), 64'(CTLV));
    wr(6'd28, CTLV | 32'h4);
    rd(6'd0, d); chk("head3_w0", 64'(d), 64'h3333_4443);
    wr(6'd28, CTLV | 32'h4);
    chk("irq_at_last_pop", 64'(irq), 64'h1);
    @(negedge clk); chk("irq_after_last_pop", 64'(irq), 64'h0);
    wr(6'd28, CTLV | 32'h4);
    rd(6'd4, d);
    chk("pop_empty_count", 64'(d[31:24]), 64'h0);
    chk("pop_empty_flag", 64'(d[3]), 64'h1);
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int k = 0; k < 8; k++)
      find(4'b0001, 64'hF0F0_0000_0000_0000 + 64'(k));
    repeat (3) @(negedge clk);
    rd(6'd4, d); chk("fill_count", 64'(d[31:24]), 64'h8);
    find(4'b0100, 64'hAAAA_0000_0000_0000);
    repeat (2) @(negedge clk);
    rd(6'd4, d);
    chk("backpressure_no_ovf", 64'(d[4]), 64'h0);
    chk("backpressure_count", 64'(d[31:24]), 64'h8);
    find(4'b0100, 64'hBBBB_0000_0000_0000);
    rd(6'd4, d); chk("ovf_set", 64'(d[4]), 64'h1);
    wr(6'd28, CTLV | 32'h8);
    rd(6'd4, d); chk("ovf_cleared", 64'(d[4]), 64'h0);
    wr(6'd28, CTLV | 32'h4);
    rd(6'd4, d); chk("refill_count", 64'(d[31:24]), 64'h8);
    rd(6'd0, d); chk("head_after_pop", 64'(d), 64'h1);
    rd(6'd4, d); chk("irq_full", 64'(d[0]), 64'h1);
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    for (int k = 0; k < 5; k++) wr(6'd28, CTLV | 32'h4);
    rd(6'd4, d); chk("pending_3", 64'(d[31:24]), 64'h3);
    @(negedge clk);
    core_found = 4'b0010;
    core_solution[127:64] = 64'hCCCC_0000_0000_0001;
    @(negedge clk);
    core_found = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("rst pulse mid-run");
    chk("midrst_irq", 64'(irq), 64'h0);
    chk("midrst_control", 64'(core_control), 64'h0);
    chk("midrst_start", core_start[127:64], 64'h0);
    repeat (3) @(negedge clk);
    rd(6'd4, d); chk("midrst_stat", 64'(d), 64'h0000_3C08);
    rd(6'd28, d); chk("midrst_ctl", 64'(d), 64'h0);
  endtask

  initial begin
    rst = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    core_found = '0; core_solution = '0; core_running = '0;
    test_reset;
    test_regs;
    test_partition;
    test_simultaneous;
    test_pop_irq;
    test_overflow;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
